// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the default HALT encoding and the
// fetch-stage state encoding.
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 8;

  localparam logic [INSTR_W-1:0] HALT_OPCODE_DEF = 8'hFF;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  // PC advances modulo 2**ADDR_W; the carry out is intentionally dropped.
  function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Program counter and fetch stage: drives the instruction memory address and
// captures the returned instruction into a one-entry IF/ID register.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC    = 8'h00,
  parameter logic [INSTR_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted
);

  fetch_state_e       r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_out_valid;
  logic [INSTR_W-1:0] r_out_instr;
  logic [ADDR_W-1:0]  r_out_pc;

  fetch_state_e       w_state_nxt;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic               w_out_valid_nxt;
  logic [INSTR_W-1:0] w_out_instr_nxt;
  logic [ADDR_W-1:0]  w_out_pc_nxt;
  logic               w_fetch;

  assign w_fetch = (r_state == ST_RUN) && !redirect_valid && (!r_out_valid || out_ready);

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_out_valid_nxt = r_out_valid;
    w_out_instr_nxt = r_out_instr;
    w_out_pc_nxt    = r_out_pc;
    // A redirect flushes the held entry even when decode consumes it this cycle.
    if (redirect_valid) begin
      w_pc_nxt        = redirect_pc;
      w_out_valid_nxt = 1'b0;
      w_state_nxt     = ST_RUN;
    end else if (w_fetch) begin
      w_out_instr_nxt = imem_instr;
      w_out_pc_nxt    = r_pc;
      w_out_valid_nxt = 1'b1;
      if (imem_instr == HALT_OPCODE) begin
        w_state_nxt = ST_HALTED;
      end else begin
        w_pc_nxt = pc_incr(r_pc);
      end
    end else if (r_out_valid && out_ready) begin
      w_out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_pc        <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_pc    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_instr <= w_out_instr_nxt;
      r_out_pc    <= w_out_pc_nxt;
    end
  end

  assign imem_pc   = r_pc;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_pc    = r_out_pc;
  assign halted    = (r_state == ST_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, a wrap-around run on a second
// instance, and randomized traffic against a behavioural model.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic [7:0] mem [256];

  logic       rst, rv, rdy;
  logic [7:0] rpc, imem_pc, imem_instr, out_instr, out_pc;
  logic       out_valid, halted;

  logic       rst2, rv2, rdy2;
  logic [7:0] rpc2, imem_pc2, imem_instr2, out_instr2, out_pc2;
  logic       out_valid2, halted2;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  assign imem_instr  = mem[imem_pc];
  assign imem_instr2 = mem[imem_pc2];

  fetch_unit #(.RESET_PC(8'h00), .HALT_OPCODE(8'hFF)) dut (
    .clk(clk), .rst(rst), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .redirect_valid(rv), .redirect_pc(rpc), .out_valid(out_valid),
    .out_ready(rdy), .out_instr(out_instr), .out_pc(out_pc), .halted(halted)
  );

  fetch_unit #(.RESET_PC(8'hFE), .HALT_OPCODE(8'hFF)) dut_fe (
    .clk(clk), .rst(rst2), .imem_pc(imem_pc2), .imem_instr(imem_instr2),
    .redirect_valid(rv2), .redirect_pc(rpc2), .out_valid(out_valid2),
    .out_ready(rdy2), .out_instr(out_instr2), .out_pc(out_pc2), .halted(halted2)
  );

  typedef struct {
    logic       rst, rv;
    logic [7:0] rpc;
    logic       rdy;
    logic       ev;
    logic [7:0] epc, einstr;
    logic       eh;
    logic [7:0] eimem;
    logic       cd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic v, logic [7:0] p, logic y, logic ev,
                              logic [7:0] epc, logic [7:0] ei, logic eh,
                              logic [7:0] em, logic cd);
    vec_t t;
    t.rst = r; t.rv = v; t.rpc = p; t.rdy = y; t.ev = ev; t.epc = epc;
    t.einstr = ei; t.eh = eh; t.eimem = em; t.cd = cd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Behavioural reference: the stage is a single-slot buffer in front of a
  // counter that stops on HALT.
  logic [7:0] m_pc, m_instr, m_opc;
  logic       m_valid, m_halted;

  task automatic model_step(input logic r, input logic v, input logic [7:0] p, input logic y);
    logic [7:0] word;
    word = mem[m_pc];
    if (r) begin
      m_pc = 8'h00; m_valid = 0; m_instr = 0; m_opc = 0; m_halted = 0;
    end else if (v) begin
      m_pc = p; m_valid = 0; m_halted = 0;
    end else if (!m_halted && (!m_valid || y)) begin
      m_valid = 1; m_instr = word; m_opc = m_pc;
      if (word == 8'hFF) m_halted = 1;
      else m_pc = (m_pc + 1) % 256;
    end else if (m_valid && y) begin
      m_valid = 0;
    end
  endtask

  initial begin
    logic [7:0] fe_exp [4];
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h20) & 8'h7F;
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
    mem[8'h04] = 8'h55; mem[8'h05] = 8'hFF; mem[8'h10] = 8'hA0; mem[8'h40] = 8'hC4;
    mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h02;

    rst = 1; rv = 0; rpc = 0; rdy = 0;
    rst2 = 1; rv2 = 0; rpc2 = 0; rdy2 = 0;

    //          rst rv rpc   rdy  ev epc    instr  h  imem   cd
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h00, 8'h11, 0, 8'h01, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h01, 8'h22, 0, 8'h02, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h02, 8'h33, 0, 8'h03, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h03, 8'h44, 0, 8'h04, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'h03, 8'h44, 0, 8'h04, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'h03, 8'h44, 0, 8'h04, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'h03, 8'h44, 0, 8'h04, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h04, 8'h55, 0, 8'h05, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h05, 8'hFF, 1, 8'h05, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'h05, 8'hFF, 1, 8'h05, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h05, 8'hFF, 1, 8'h05, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h05, 8'hFF, 1, 8'h05, 0));
    tbl.push_back(mk(0, 1, 8'h10, 1, 0, 8'h00, 8'h00, 0, 8'h10, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h10, 8'hA0, 0, 8'h11, 1));
    tbl.push_back(mk(0, 1, 8'h40, 1, 0, 8'h00, 8'h00, 0, 8'h40, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h40, 8'hC4, 0, 8'h41, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'h40, 8'hC4, 0, 8'h41, 1));
    tbl.push_back(mk(1, 1, 8'h33, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1));

    // Directed table on the RESET_PC=00 instance.
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; rv = tbl[i].rv; rpc = tbl[i].rpc; rdy = tbl[i].rdy;
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("v%0d_halted", i), 32'(halted), 32'(tbl[i].eh));
      chk($sformatf("v%0d_imem_pc", i), 32'(imem_pc), 32'(tbl[i].eimem));
      if (tbl[i].cd) begin
        chk($sformatf("v%0d_out_pc", i), 32'(out_pc), 32'(tbl[i].epc));
        chk($sformatf("v%0d_out_instr", i), 32'(out_instr), 32'(tbl[i].einstr));
      end
    end

    // Flush check: after a redirect from 02 the stale (02,33) must never surface.
    rst = 1; rv = 0; rdy = 1; @(posedge clk); #1;
    rst = 0; @(posedge clk); #1;
    @(posedge clk); #1;
    rv = 1; rpc = 8'h40; @(posedge clk); #1;
    chk("flush_valid", 32'(out_valid), 32'd0);
    rv = 0; @(posedge clk); #1;
    chk("flush_tgt_pc", 32'(out_pc), 32'h40);
    chk("flush_tgt_instr", 32'(out_instr), 32'hC4);

    // Wrap-around on the RESET_PC=FE instance.
    fe_exp[0] = 8'hFE; fe_exp[1] = 8'hFF; fe_exp[2] = 8'h00; fe_exp[3] = 8'h01;
    rst2 = 1; @(posedge clk); #1;
    chk("wrap_reset_imem", 32'(imem_pc2), 32'hFE);
    rst2 = 0; rdy2 = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("wrap%0d_pc", i), 32'(out_pc2), 32'(fe_exp[i]));
      chk($sformatf("wrap%0d_instr", i), 32'(out_instr2), 32'(mem[fe_exp[i]]));
      chk($sformatf("wrap%0d_valid", i), 32'(out_valid2), 32'd1);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom);
    m_pc = 0; m_valid = 0; m_instr = 0; m_opc = 0; m_halted = 0;
    for (int c = 0; c < 600; c++) begin
      rst = (c == 0) || ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = 8'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      model_step(rst, rv, rpc, rdy);
      @(posedge clk); #1;
      chk("rnd_valid", 32'(out_valid), 32'(m_valid));
      chk("rnd_halted", 32'(halted), 32'(m_halted));
      chk("rnd_imem_pc", 32'(imem_pc), 32'(m_pc));
      if (m_valid) begin
        chk("rnd_out_pc", 32'(out_pc), 32'(m_opc));
        chk("rnd_out_instr", 32'(out_instr), 32'(m_instr));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
